// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a 60-word store, round keys served by index.
// Optional feature macro: AES_KEYEXP_REVERSE_EN adds rk_rev to read round keys in decryption order.
module aes_key_expander (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mod,
    input  logic [255:0] key,
`ifdef AES_KEYEXP_REVERSE_EN
    input  logic         rk_rev,
`endif
    input  logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   nr,
    output logic [127:0] rk_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         state_r;
    logic [1:0]     mod_r;
    logic [255:0]   key_r;
    logic [31:0]    w_r [0:59];
    logic [5:0]     i_r;
    logic [2:0]     j_r;
    logic [7:0]     rcon_r;
    logic           busy_r, done_r, err_r;
    logic [3:0]     nr_r;
    logic [127:0]   rk_out_r;

    logic [5:0]     nk_s, last_s;
    logic [3:0]     nr_new_s, idx_s, sel_s;
    logic [5:0]     base_s;
    logic           range_ok_s, j_last_s;
    logic [31:0]    prev_s, sub_in_s, sub_s, temp_s, new_word_s;

    // Key-size decode and next schedule word.
    always_comb begin
        nk_s     = 6'd4;
        last_s   = 6'd43;
        nr_new_s = 4'd10;
        case (mod_r)
            2'b00:   begin nk_s = 6'd4; last_s = 6'd43; nr_new_s = 4'd10; end
            2'b01:   begin nk_s = 6'd6; last_s = 6'd51; nr_new_s = 4'd12; end
            2'b10:   begin nk_s = 6'd8; last_s = 6'd59; nr_new_s = 4'd14; end
            default: begin nk_s = 6'd4; last_s = 6'd43; nr_new_s = 4'd10; end
        endcase
        j_last_s = ({3'b000, j_r} == (nk_s - 6'd1));
        prev_s   = w_r[i_r - 6'd1];
        // RotWord only feeds the S-box at the start of each Nk-word group.
        if (j_r == 3'd0) begin
            sub_in_s = {prev_s[23:0], prev_s[31:24]};
        end else begin
            sub_in_s = prev_s;
        end
        sub_s = sub_word(sub_in_s);
        if (j_r == 3'd0) begin
            temp_s = sub_s ^ {rcon_r, 24'h000000};
        end else if ((nk_s == 6'd8) && (j_r == 3'd4)) begin
            temp_s = sub_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = w_r[i_r - nk_s] ^ temp_s;
    end

    // Read index selection; out-of-range indices are clamped so the store is never over-indexed.
    always_comb begin
`ifdef AES_KEYEXP_REVERSE_EN
        if (rk_rev) begin
            idx_s = nr_r - rk_idx;
        end else begin
            idx_s = rk_idx;
        end
`else
        idx_s = rk_idx;
`endif
        range_ok_s = !busy_r && (nr_r != 4'd0) && (rk_idx <= nr_r);
        if (range_ok_s) begin
            sel_s = idx_s;
        end else begin
            sel_s = 4'd0;
        end
        base_s = {sel_s, 2'b00};
    end

    // Control FSM and round-key store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mod_r   <= 2'b00;
            key_r   <= 256'h0;
            i_r     <= 6'd8;
            j_r     <= 3'd0;
            rcon_r  <= 8'h01;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            nr_r    <= 4'd0;
            for (int n = 0; n < 60; n++) begin
                w_r[n] <= 32'h0;
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (mod == 2'b11) begin
                            err_r <= 1'b1;
                        end else begin
                            mod_r   <= mod;
                            key_r   <= key;
                            busy_r  <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    for (int n = 0; n < 8; n++) begin
                        if (6'(n) < nk_s) begin
                            w_r[n] <= key_r[255 - 32*n -: 32];
                        end
                    end
                    i_r     <= nk_s;
                    j_r     <= 3'd0;
                    rcon_r  <= 8'h01;
                    state_r <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    w_r[i_r] <= new_word_s;
                    i_r      <= i_r + 6'd1;
                    j_r      <= j_last_s ? 3'd0 : (j_r + 3'd1);
                    if (j_r == 3'd0) begin
                        rcon_r <= xtime(rcon_r);
                    end
                    if (i_r == last_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        nr_r    <= nr_new_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered round-key read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_out_r <= 128'h0;
        end else if (!range_ok_s) begin
            rk_out_r <= 128'h0;
        end else begin
            rk_out_r <= {w_r[base_s], w_r[base_s + 6'd1], w_r[base_s + 6'd2], w_r[base_s + 6'd3]};
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign nr     = nr_r;
    assign rk_out = rk_out_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: randomized keys against an arithmetic key-schedule model.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   mod;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic         busy, done, err;
    logic [3:0]   nr;
    logic [127:0] rk_out;
`ifdef AES_KEYEXP_REVERSE_EN
    logic         rk_rev;
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    aes_key_expander dut (
        .clk(clk), .reset(reset), .start(start), .mod(mod), .key(key),
`ifdef AES_KEYEXP_REVERSE_EN
        .rk_rev(rk_rev),
`endif
        .rk_idx(rk_idx), .busy(busy), .done(done), .err(err), .nr(nr), .rk_out(rk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [3:0] nr;
        int         at;
    } ev_t;

    ev_t          ev_q[$];
    logic [127:0] rd_q[$];
    bit           rd_req = 1'b0;
    bit           rd_armed = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic [7:0]   sbox_t [0:255];
    logic [31:0]  ref_w [0:59];
    logic [3:0]   cur_nr = 4'd0;

    localparam logic [127:0] KAT128_0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT128_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KAT128_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KAT192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] KAT256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int n = 0; n < 254; n++) inv = gmul(inv, 8'(x));
            end
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_ref(input logic [1:0] m, input logic [255:0] k);
        int nk, total;
        logic [31:0] t;
        logic [7:0] rc;
        nk = 4 + 2 * int'(m);
        total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input logic [3:0] idx, input bit rev);
        int kk;
        if (cur_nr == 4'd0 || idx > cur_nr) return 128'h0;
        kk = rev ? int'(cur_nr) - int'(idx) : int'(idx);
        return {ref_w[4*kk], ref_w[4*kk+1], ref_w[4*kk+2], ref_w[4*kk+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data and handshake events as the DUT presents them.
    initial begin
        ev_t e;
        logic [127:0] x;
        forever begin
            @(negedge clk);
            if (rd_armed) begin
                if (rd_q.size() == 0) begin
                    chk("rd_queue_underflow", 128'h1, 128'h0);
                end else begin
                    x = rd_q.pop_front();
                    chk("rk_out", rk_out, x);
                end
            end
            rd_armed = rd_req;
            if (done === 1'b1 || err === 1'b1) begin
                vectors++;
                if (ev_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: done=%0b err=%0b at edge %0d", done, err, cyc);
                end else begin
                    e = ev_q.pop_front();
                    if (err !== e.is_err || done !== !e.is_err || nr !== e.nr || busy !== 1'b0 || cyc != e.at) begin
                        miscompares++;
                        $display("FAIL event: got done=%0b err=%0b nr=%0d busy=%0b edge=%0d, expected err=%0b nr=%0d busy=0 edge=%0d",
                                 done, err, nr, busy, cyc, e.is_err, e.nr, e.at);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_events(input int budget);
        for (int n = 0; n < budget && ev_q.size() != 0; n++) tick();
        if (ev_q.size() != 0) begin
            chk("event_timeout", 128'(ev_q.size()), 128'h0);
            ev_q.delete();
        end
    endtask

    task automatic rd(input logic [3:0] idx, input bit rev, input logic [127:0] exp);
        rk_idx = idx;
`ifdef AES_KEYEXP_REVERSE_EN
        rk_rev = rev;
`endif
        rd_q.push_back(exp);
        rd_req = 1'b1;
        tick();
    endtask

    task automatic rd_end();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic run(input logic [1:0] m, input logic [255:0] k, input bit mid_start);
        ev_t e;
        int nk;
        nk = 4 + 2 * int'(m);
        mod = m;
        key = k;
        start = 1'b1;
        e.is_err = 1'b0;
        e.nr = 4'(nk + 6);
        e.at = cyc + 2 + 4 * (nk + 7) - nk;
        ev_q.push_back(e);
        tick();
        start = 1'b0;
        if (mid_start) begin
            repeat (10) tick();
            chk("busy_mid_expand", 128'(busy), 128'h1);
            mod = 2'($urandom_range(0, 3));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_events(100);
        build_ref(m, k);
        cur_nr = 4'(nk + 6);
    endtask

    initial begin
        logic [255:0] rk;
        logic [3:0] idx;
        bit rev;
        ev_t e;
        build_sbox();
        reset = 1'b1;
        start = 1'b0;
        mod = 2'b00;
        key = 256'h0;
        rk_idx = 4'd0;
`ifdef AES_KEYEXP_REVERSE_EN
        rk_rev = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_done", 128'(done), 128'h0);
        chk("reset_err", 128'(err), 128'h0);
        chk("reset_nr", 128'(nr), 128'h0);
        chk("reset_rk_out", rk_out, 128'h0);

        // AES-128 known answer, junk in the ignored low key bits.
        run(2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef_cafef00d_12345678_9abcdef0}, 1'b0);
        rd(4'd0, 1'b0, KAT128_0);
        rd(4'd1, 1'b0, KAT128_1);
        rd(4'd10, 1'b0, KAT128_10);
        rd(4'd12, 1'b0, 128'h0);
        rd_end();

        // Illegal mode: err pulse the cycle after sampling, schedule untouched.
        mod = 2'b11;
        key = 256'h0;
        start = 1'b1;
        e.is_err = 1'b1;
        e.nr = cur_nr;
        e.at = cyc + 1;
        ev_q.push_back(e);
        tick();
        start = 1'b0;
        chk("err_busy", 128'(busy), 128'h0);
        wait_events(10);
        rd(4'd10, 1'b0, KAT128_10);
        rd(4'd1, 1'b0, KAT128_1);
        rd_end();

        // AES-192 known answer with an ignored start mid-expansion.
        run(2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0123456789abcdef}, 1'b1);
        rd(4'd12, 1'b0, KAT192_12);
        rd(4'd13, 1'b0, 128'h0);
        rd_end();

        for (int r = 0; r < 6; r++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run(2'($urandom_range(0, 2)), rk, 1'($urandom_range(0, 1)));
            for (int n = 0; n < 10; n++) begin
                idx = 4'($urandom_range(0, 15));
                rev = REV_EN & 1'($urandom_range(0, 1));
                rd(idx, rev, exp_rk(idx, rev));
            end
            rd_end();
        end

        // Reset during the 20th EXPAND cycle discards the run.
        mod = 2'b00;
        key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_nr = 4'd0;
        chk("abort_busy", 128'(busy), 128'h0);
        chk("abort_nr", 128'(nr), 128'h0);
        chk("abort_done", 128'(done), 128'h0);
        rd(4'd0, 1'b0, 128'h0);
        rd(4'd3, 1'b0, 128'h0);
        rd_end();
        repeat (60) tick();

        // Fresh AES-256 after the abort.
        run(2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        rd(4'd14, 1'b0, KAT256_14);
        rd(4'd15, 1'b0, 128'h0);
`ifdef AES_KEYEXP_REVERSE_EN
        rd(4'd0, 1'b1, KAT256_14);
        rd(4'd15, 1'b1, 128'h0);
`endif
        rd_end();

        repeat (3) tick();
        if (ev_q.size() != 0 || rd_q.size() != 0) begin
            chk("leftover_expectations", 128'(ev_q.size() + rd_q.size()), 128'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
